// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Multicycle control unit for the tipo/op/inm instruction set. An instruction
// is accepted from the fetch unit with a valid/ready handshake. It is then
// sequenced through FETCH/DECODE/EXEC/MEMADR/MEM/WB/BRANCH. Per-state
// datapath controls are decoded from the current state and the latched
// instruction fields.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   instr_valid/ready   instruction handshake with the fetch unit
//   tipo, op, inm       instruction fields (sampled only at the handshake)
//   zero                ALU zero flag, used to resolve BEQ
//   mem_ready           data memory completes the current access
//   ir_write .. pc_write  datapath controls
//   illegal             one-cycle pulse: illegal opcode or memory timeout
//   busy                high in every state except FETCH
//   retired             count of completed instructions (wraps)
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int OP_W        = 2,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [1:0]         tipo,
  input  logic [OP_W-1:0]    op,
  input  logic               inm,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               reg_write,
  output logic               link_write,
  output logic [1:0]         imm_src,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               flag_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               result_src,
  output logic               pc_write,
  output logic               illegal,
  output logic               busy,
  output logic [CNT_W-1:0]   retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [ALUOP_W-1:0] ALU_PASS  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_CMP   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_ARITH = ALUOP_W'(2);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEMADR, S_MEM, S_WB, S_BRANCH
  } state_t;

  state_t              state_reg, state_next;
  logic [1:0]          tipo_q;
  logic [OP_W-1:0]     op_q;
  logic                inm_q;
  logic [WAIT_W-1:0]   wait_reg, wait_next;
  logic [CNT_W-1:0]    retired_reg;
  logic                retire;

  // Instruction classification from the latched fields only.
  logic       op_hi_zero;
  logic [1:0] op_lo;
  logic is_arith, is_mov, is_ldr, is_str, is_b, is_bl, is_cmp, is_beq;

  assign op_lo = op_q[1:0];

  // Any op code of 4 or more is illegal, whatever the type.
  generate
    if (OP_W > 2) begin : g_op_hi
      assign op_hi_zero = (op_q[OP_W-1:2] == '0);
    end else begin : g_op_narrow
      assign op_hi_zero = 1'b1;
    end
  endgenerate

  assign is_arith = op_hi_zero && (tipo_q == 2'b00);
  assign is_mov   = op_hi_zero && (tipo_q == 2'b01) && (op_lo == 2'b00);
  assign is_ldr   = op_hi_zero && (tipo_q == 2'b01) && (op_lo == 2'b01);
  assign is_str   = op_hi_zero && (tipo_q == 2'b01) && (op_lo == 2'b10);
  assign is_b     = op_hi_zero && (tipo_q == 2'b10) && (op_lo == 2'b00);
  assign is_bl    = op_hi_zero && (tipo_q == 2'b10) && (op_lo == 2'b01);
  assign is_cmp   = op_hi_zero && (tipo_q == 2'b10) && (op_lo == 2'b10);
  assign is_beq   = op_hi_zero && (tipo_q == 2'b10) && (op_lo == 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      tipo_q      <= '0;
      op_q        <= '0;
      inm_q       <= 1'b0;
      wait_reg    <= '0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      if (retire) begin
        retired_reg <= retired_reg + 1'b1;
      end
      if (state_reg == S_FETCH && instr_valid) begin
        tipo_q <= tipo;
        op_q   <= op;
        inm_q  <= inm;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    wait_next   = wait_reg;
    retire      = 1'b0;
    instr_ready = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    link_write  = 1'b0;
    imm_src     = 2'b00;
    alu_src     = 1'b0;
    alu_op      = ALU_PASS;
    flag_write  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    result_src  = 1'b0;
    pc_write    = 1'b0;
    illegal     = 1'b0;

    case (state_reg)
      S_FETCH: begin
        instr_ready = 1'b1;
        // Reset holds the FSM in FETCH; keep the IR latch quiet meanwhile.
        if (instr_valid && !rst) begin
          ir_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_arith || is_mov || is_cmp) begin
          state_next = S_EXEC;
        end else if (is_ldr || is_str) begin
          state_next = S_MEMADR;
        end else if (is_b || is_bl || is_beq) begin
          state_next = S_BRANCH;
        end else begin
          illegal    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src = inm_q;
        if (is_arith) begin
          alu_op = ALU_ARITH;
        end else if (is_cmp) begin
          alu_op = ALU_CMP;
        end
        if (is_cmp) begin
          flag_write = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEMADR: begin
        alu_src    = inm_q;
        imm_src    = 2'b01;
        wait_next  = '0;
        state_next = S_MEM;
      end
      S_MEM: begin
        mem_read  = is_ldr;
        mem_write = is_str;
        if (mem_ready) begin
          // A ready arriving in the last allowed cycle still succeeds.
          if (is_str) begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (wait_reg == WAIT_LAST) begin
          // This is the MEM_TIMEOUT-th cycle without ready: abort.
          illegal    = 1'b1;
          wait_next  = '0;
          state_next = S_FETCH;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        result_src = is_ldr;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        imm_src    = 2'b10;
        pc_write   = is_beq ? zero : 1'b1;
        link_write = is_bl;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  assign busy    = (state_reg != S_FETCH);
  assign retired = retired_reg;

endmodule
